ones_frame_accumulator: RTL

Sequential stage directly downstream of `count_16_bit`. It consumes the per-word 5-bit ones count over a valid/ready handshake and accumulates it over a fixed-length frame of words. It then presents per-frame statistics (total ones, per-word maximum, number of all-ones words) on an output valid/ready handshake. This converts the combinational per-word popcount into frame-level figures for the downstream consumer.

---
 rtl/ones_frame_accumulator_if.sv | 26 ++
 rtl/ones_frame_accumulator.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ones_frame_accumulator_if.sv
// Handshake bundle between count_16_bit's output stream and the frame consumer.
// slave = the accumulator side, master = the side driving counts / taking frames.
interface ones_frame_accumulator_if #(
  parameter int SUM_WIDTH = 12
);
  logic [4:0]           count_in;
  logic                 count_valid;
  logic                 count_ready;
  logic                 clear;
  logic [SUM_WIDTH-1:0] frame_sum;
  logic [4:0]           frame_max;
  logic [7:0]           full_words;
  logic                 err_range;
  logic                 frame_valid;
  logic                 frame_ready;

  modport slave (
    input  count_in, count_valid, clear, frame_ready,
    output count_ready, frame_sum, frame_max, full_words, err_range, frame_valid
  );

  modport master (
    output count_in, count_valid, clear, frame_ready,
    input  count_ready, frame_sum, frame_max, full_words, err_range, frame_valid
  );
endinterface

// File: rtl/ones_frame_accumulator.sv
// Accumulates per-word popcounts over FRAME_WORDS accepted words, then holds
// frame statistics (sum, max, all-ones word count, range error) until taken.
module ones_frame_accumulator #(
  parameter int FRAME_WORDS = 8,
  parameter int SUM_WIDTH   = 12
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  ones_frame_accumulator_if.slave   bus
);
  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [7:0] LAST = 8'(FRAME_WORDS - 1);

  state_t               r_state, w_state_nxt;
  logic [SUM_WIDTH-1:0] r_sum, w_sum_nxt, r_osum, w_osum_nxt;
  logic [4:0]           r_max, w_max_nxt, r_omax, w_omax_nxt;
  logic [7:0]           r_full, w_full_nxt, r_ofull, w_ofull_nxt;
  logic                 r_err, w_err_nxt, r_oerr, w_oerr_nxt;
  logic [7:0]           r_cnt, w_cnt_nxt;
  logic                 r_ovld, w_ovld_nxt;

  logic                 w_ready, w_acc, w_oor, w_is16;
  logic [4:0]           w_sat, w_max_upd;
  logic [SUM_WIDTH-1:0] w_sum_upd;
  logic [7:0]           w_full_upd;
  logic                 w_err_upd;

  // Out-of-range counts are saturated to 16 but never count as all-ones words
  assign w_oor      = bus.count_in > 5'd16;
  assign w_is16     = bus.count_in == 5'd16;
  assign w_sat      = w_oor ? 5'd16 : bus.count_in;
  assign w_ready    = (r_state == ACCUM) && i_rst_n;
  assign w_acc      = bus.count_valid && w_ready && !bus.clear;
  assign w_sum_upd  = r_sum + SUM_WIDTH'(w_sat);
  assign w_max_upd  = (w_sat > r_max) ? w_sat : r_max;
  assign w_full_upd = r_full + 8'(w_is16);
  assign w_err_upd  = r_err | w_oor;

  always_comb begin
    w_state_nxt = r_state;
    w_sum_nxt   = r_sum;
    w_max_nxt   = r_max;
    w_full_nxt  = r_full;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;
    w_osum_nxt  = r_osum;
    w_omax_nxt  = r_omax;
    w_ofull_nxt = r_ofull;
    w_oerr_nxt  = r_oerr;
    w_ovld_nxt  = r_ovld;
    case (r_state)
      ACCUM: begin
        if (bus.clear) begin
          w_sum_nxt  = '0;
          w_max_nxt  = '0;
          w_full_nxt = '0;
          w_err_nxt  = 1'b0;
          w_cnt_nxt  = '0;
        end else if (w_acc) begin
          if (r_cnt == LAST) begin
            // Last word lands directly in the output registers; accumulators restart
            w_osum_nxt  = w_sum_upd;
            w_omax_nxt  = w_max_upd;
            w_ofull_nxt = w_full_upd;
            w_oerr_nxt  = w_err_upd;
            w_ovld_nxt  = 1'b1;
            w_sum_nxt   = '0;
            w_max_nxt   = '0;
            w_full_nxt  = '0;
            w_err_nxt   = 1'b0;
            w_cnt_nxt   = '0;
            w_state_nxt = HOLD;
          end else begin
            w_sum_nxt  = w_sum_upd;
            w_max_nxt  = w_max_upd;
            w_full_nxt = w_full_upd;
            w_err_nxt  = w_err_upd;
            w_cnt_nxt  = r_cnt + 8'd1;
          end
        end
      end
      HOLD: begin
        if (bus.frame_ready) begin
          w_osum_nxt  = '0;
          w_omax_nxt  = '0;
          w_ofull_nxt = '0;
          w_oerr_nxt  = 1'b0;
          w_ovld_nxt  = 1'b0;
          w_sum_nxt   = '0;
          w_max_nxt   = '0;
          w_full_nxt  = '0;
          w_err_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = ACCUM;
        end
      end
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ACCUM;
      r_sum   <= '0;
      r_max   <= '0;
      r_full  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_osum  <= '0;
      r_omax  <= '0;
      r_ofull <= '0;
      r_oerr  <= 1'b0;
      r_ovld  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sum   <= w_sum_nxt;
      r_max   <= w_max_nxt;
      r_full  <= w_full_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
      r_osum  <= w_osum_nxt;
      r_omax  <= w_omax_nxt;
      r_ofull <= w_ofull_nxt;
      r_oerr  <= w_oerr_nxt;
      r_ovld  <= w_ovld_nxt;
    end
  end

  assign bus.count_ready = w_ready;
  assign bus.frame_sum   = r_osum;
  assign bus.frame_max   = r_omax;
  assign bus.full_words  = r_ofull;
  assign bus.err_range   = r_oerr;
  assign bus.frame_valid = r_ovld;
endmodule
